expr_vector_sequencer: RTL and testbench

Sequences stimulus into the combinational expression blocks of the regression suite (6-operand A/B banks, 90-bit `y`). It generates pseudo-random operand vectors from a 60-bit LFSR and holds each vector for a programmable settle time. It then captures the DUT output and compresses it into a 32-bit MISR signature. One run is started by a pulse; the final signature is compared against a golden value by the testbench or host.

---
 rtl/expr_vector_sequencer_if.sv | 28 ++
 rtl/expr_vector_sequencer.sv | 125 ++++++++++++
 tb/tb_expr_vector_sequencer.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/expr_vector_sequencer_if.sv
// Host-side bundle for the expression-block vector sequencer: run control, operand buses, DUT result, status.
// Latency: pure wiring, no state.
// Backpressure: none; the master owns start/abort/num_vec/settle/y_in, the slave owns everything else.
interface expr_vector_sequencer_if #(
    parameter int Y_W = 90
);
    logic           start;
    logic           abort;
    logic [15:0]    num_vec;
    logic [3:0]     settle;
    logic [29:0]    a_bus;
    logic [29:0]    b_bus;
    logic [Y_W-1:0] y_in;
    logic           busy;
    logic           done;
    logic [31:0]    signature;
    logic [15:0]    vec_cnt;

    modport master (
        output start, abort, num_vec, settle, y_in,
        input  a_bus, b_bus, busy, done, signature, vec_cnt
    );

    modport slave (
        input  start, abort, num_vec, settle, y_in,
        output a_bus, b_bus, busy, done, signature, vec_cnt
    );
endinterface

// File: rtl/expr_vector_sequencer.sv
// Operand sequencer: drives 60-bit LFSR vectors into a combinational DUT and folds its 90-bit output into a 32-bit MISR.
// Latency: each vector takes settle+2 cycles (drive, settle waits, capture); done pulses one cycle after the DONE state.
// Backpressure: none; start is honoured only when idle, abort cancels any busy cycle on the next edge.
module expr_vector_sequencer #(
    parameter logic [59:0] SEED = 60'h1,
    parameter int          Y_W  = 90
) (
    input  logic                   clk,
    input  logic                   rst_n,
    expr_vector_sequencer_if.slave bus
);

    // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
    localparam logic [59:0] SEED_EFF = (SEED == 60'h0) ? 60'h1 : SEED;
    localparam logic [31:0] POLY     = 32'h04C11DB7;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_DRIVE   = 3'd1,
        S_WAIT    = 3'd2,
        S_CAPTURE = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t      state;
    logic [59:0] lfsr;
    logic [59:0] vec_q;
    logic [31:0] sig;
    logic [15:0] cnt;
    logic [15:0] nv_q;
    logic [3:0]  st_q;
    logic [3:0]  wait_cnt;
    logic        busy_q;
    logic        done_q;

    logic [31:0] fold;
    logic [31:0] sig_next;
    logic [15:0] cnt_inc;
    logic [59:0] lfsr_next;

    // Fold the DUT output to 32 bits and form the next MISR, count and LFSR values used at capture.
    always_comb begin
        fold      = bus.y_in[31:0] ^ bus.y_in[63:32] ^ {{(96-Y_W){1'b0}}, bus.y_in[Y_W-1:64]};
        sig_next  = {sig[30:0], 1'b0} ^ (sig[31] ? POLY : 32'h0) ^ fold;
        cnt_inc   = cnt + 16'd1;
        lfsr_next = {lfsr[58:0], lfsr[59] ^ lfsr[58]};
    end

    // Run FSM with registered busy/done; abort wins over every busy-state action.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            lfsr     <= SEED_EFF;
            vec_q    <= 60'h0;
            sig      <= 32'h0;
            cnt      <= 16'h0;
            nv_q     <= 16'h0;
            st_q     <= 4'h0;
            wait_cnt <= 4'h0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        sig <= 32'hFFFF_FFFF;
                        cnt <= 16'h0;
                        if (bus.num_vec != 16'h0) begin
                            lfsr  <= SEED_EFF;
                            nv_q  <= bus.num_vec;
                            st_q  <= bus.settle;
                            state <= S_DRIVE;
                        end else begin
                            state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    done_q <= 1'b1;
                    state  <= S_IDLE;
                end
                default: begin
                    if (bus.abort) begin
                        state <= S_IDLE;
                    end else begin
                        busy_q <= 1'b1;
                        case (state)
                            S_DRIVE: begin
                                vec_q    <= lfsr;
                                wait_cnt <= st_q;
                                state    <= (st_q != 4'h0) ? S_WAIT : S_CAPTURE;
                            end
                            S_WAIT: begin
                                wait_cnt <= wait_cnt - 4'd1;
                                if (wait_cnt == 4'd1) begin
                                    state <= S_CAPTURE;
                                end
                            end
                            S_CAPTURE: begin
                                sig   <= sig_next;
                                cnt   <= cnt_inc;
                                lfsr  <= lfsr_next;
                                state <= (cnt_inc == nv_q) ? S_DONE : S_DRIVE;
                            end
                            default: begin
                                busy_q <= 1'b0;
                                state  <= S_IDLE;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    assign bus.a_bus     = vec_q[59:30];
    assign bus.b_bus     = vec_q[29:0];
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.signature = sig;
    assign bus.vec_cnt   = cnt;

endmodule

// File: tb/tb_expr_vector_sequencer.sv
// Bench for expr_vector_sequencer: table of run configurations plus hand sequences for reset, abort and reset mid-run.
// Latency: expected edges derived from settle+2 cycles per vector.
// Backpressure: none; the bench drives the master side of the interface directly.
module tb_expr_vector_sequencer;

    localparam logic [59:0] SEED = 60'h1;

    logic clk;
    logic rst_n;
    logic ymode;
    int   n_checks;
    int   n_fail;

    expr_vector_sequencer_if #(.Y_W(90)) bus ();

    expr_vector_sequencer #(.SEED(SEED), .Y_W(90)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the combinational expression block under test.
    function automatic logic [89:0] dut_model(input logic [59:0] v);
        return {v[59:30], v[29:0] + 30'h0012345, v[59:30] ^ {v[14:0], v[29:15]}};
    endfunction

    function automatic logic [59:0] lfsr_step(input logic [59:0] v);
        return {v[58:0], v[59] ^ v[58]};
    endfunction

    function automatic logic [31:0] model_sig(input int n, input bit ym);
        logic [31:0] s;
        logic [59:0] v;
        logic [89:0] y;
        logic [31:0] f;
        s = 32'hFFFF_FFFF;
        v = SEED;
        for (int k = 0; k < n; k++) begin
            y = ym ? dut_model(v) : 90'h0;
            f = y[31:0] ^ y[63:32] ^ {6'b0, y[89:64]};
            s = {s[30:0], 1'b0} ^ (s[31] ? 32'h04C11DB7 : 32'h0) ^ f;
            v = lfsr_step(v);
        end
        return s;
    endfunction

    assign bus.y_in = ymode ? dut_model({bus.a_bus, bus.b_bus}) : 90'h0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [15:0] nv;
        logic [3:0]  st;
        bit          ym;
        logic [31:0] exp_sig;
        int          exp_done;
        int          exp_busy;
    } vec_t;

    vec_t tbl[6];

    task automatic run_row(input int idx, input vec_t r);
        logic [59:0] v;
        logic [59:0] hold_ab;
        int per, nv, done_at, done_cnt, busy_cyc;
        per = int'(r.st) + 2;
        nv  = int'(r.nv);
        v   = SEED;
        done_at = -1; done_cnt = 0; busy_cyc = 0;
        @(negedge clk);
        hold_ab = {bus.a_bus, bus.b_bus};
        ymode = r.ym;
        bus.num_vec = r.nv;
        bus.settle  = r.st;
        bus.start   = 1'b1;
        @(posedge clk);
        #1;
        bus.start   = 1'b0;
        bus.num_vec = ~r.nv;
        bus.settle  = ~r.st;
        for (int e = 1; e <= nv * per + 4; e++) begin
            @(posedge clk);
            #1;
            if (bus.busy) busy_cyc++;
            if (bus.done) begin
                done_cnt++;
                if (done_at < 0) done_at = e;
            end
            if (nv != 0 && (e - 1) % per == 0 && (e - 1) / per < nv)
                check($sformatf("row%0d drive%0d", idx, (e - 1) / per), {4'h0, bus.a_bus, bus.b_bus}, {4'h0, v});
            if (nv != 0 && e % per == 0 && e / per <= nv) begin
                check($sformatf("row%0d vec_cnt@%0d", idx, e), {48'h0, bus.vec_cnt}, 64'(e / per));
                v = lfsr_step(v);
            end
        end
        check($sformatf("row%0d done_edge", idx), 64'(done_at), 64'(r.exp_done));
        check($sformatf("row%0d done_pulses", idx), 64'(done_cnt), 64'd1);
        check($sformatf("row%0d busy_cycles", idx), 64'(busy_cyc), 64'(r.exp_busy));
        check($sformatf("row%0d signature", idx), {32'h0, bus.signature}, {32'h0, r.exp_sig});
        check($sformatf("row%0d vec_cnt", idx), {48'h0, bus.vec_cnt}, {48'h0, r.nv});
        if (nv == 0)
            check($sformatf("row%0d ab_hold", idx), {4'h0, bus.a_bus, bus.b_bus}, {4'h0, hold_ab});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        tbl[0] = '{16'd1, 4'd0,  1'b0, 32'hFB3EE249, 3,  2};
        tbl[1] = '{16'd2, 4'd0,  1'b0, 32'hF2BCD925, 5,  4};
        tbl[2] = '{16'd4, 4'd3,  1'b1, model_sig(4, 1'b1), 21, 20};
        tbl[3] = '{16'd0, 4'd5,  1'b1, 32'hFFFFFFFF, 1,  0};
        tbl[4] = '{16'd3, 4'd1,  1'b1, model_sig(3, 1'b1), 10, 9};
        tbl[5] = '{16'd5, 4'd15, 1'b1, model_sig(5, 1'b1), 86, 85};

        // Reset held with stimulus toggling.
        rst_n = 1'b0;
        ymode = 1'b1;
        bus.start = 1'b0; bus.abort = 1'b0; bus.num_vec = 16'd0; bus.settle = 4'd0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.start   = i[0];
            bus.abort   = ~i[0];
            bus.num_vec = 16'(i + 3);
            bus.settle  = 4'(i);
            @(posedge clk);
            #1;
            check("reset busy_done", {62'h0, bus.busy, bus.done}, 64'h0);
            check("reset ab", {4'h0, bus.a_bus, bus.b_bus}, 64'h0);
            check("reset sig_cnt", {16'h0, bus.signature, bus.vec_cnt}, 64'h0);
        end
        @(negedge clk);
        bus.start = 1'b0; bus.abort = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // First row starts on the first edge after reset release.
        for (int i = 0; i < 6; i++) run_row(i, tbl[i]);

        // Abort in the third WAIT with a start pulse earlier in the run.
        @(negedge clk);
        ymode = 1'b1;
        bus.num_vec = 16'd8;
        bus.settle  = 4'd2;
        bus.start   = 1'b1;
        @(posedge clk);
        for (int e = 1; e <= 16; e++) begin
            @(negedge clk);
            bus.start = (e == 5);
            bus.abort = (e == 10);
            @(posedge clk);
            #1;
            if (e == 9) check("abort busy_before", {63'h0, bus.busy}, 64'h1);
            if (e >= 10) check($sformatf("abort busy@%0d", e), {63'h0, bus.busy}, 64'h0);
            check($sformatf("abort no_done@%0d", e), {63'h0, bus.done}, 64'h0);
        end
        bus.abort = 1'b0;
        check("abort vec_cnt", {48'h0, bus.vec_cnt}, 64'd2);
        check("abort signature", {32'h0, bus.signature}, {32'h0, model_sig(2, 1'b1)});

        // Reset asserted mid-run clears outputs immediately.
        @(negedge clk);
        bus.num_vec = 16'd3;
        bus.settle  = 4'd1;
        bus.start   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("midreset busy_done", {62'h0, bus.busy, bus.done}, 64'h0);
        check("midreset ab", {4'h0, bus.a_bus, bus.b_bus}, 64'h0);
        check("midreset sig_cnt", {16'h0, bus.signature, bus.vec_cnt}, 64'h0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("midreset no_done", {63'h0, bus.done}, 64'h0);
        end
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
